// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the dual-port SRAM arbiter slice.
package sram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    logic  mid;
    port_e port;
  } rd_entry_t;

endpackage

// File: rtl/sram_rd_tracker.sv
// Read-return pipeline: one lane per SRAM port, each RD_LAT deep, routed to masters at exit.
module sram_rd_tracker
  import sram_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  rd_entry_t [1:0]       push_i,
  input  logic [DATA_W-1:0]     i_dout0,
  input  logic [DATA_W-1:0]     i_dout1,
  output logic                  m0_rvalid_o,
  output logic [DATA_W-1:0]     m0_rdata_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_W-1:0]     m1_rdata_o
);

  rd_entry_t [1:0][RD_LAT-1:0] pipe_q, pipe_d;
  logic [DATA_W-1:0]           lane_data;

  always_comb begin
    pipe_d = pipe_q;
    for (int unsigned l = 0; l < 2; l++) begin
      pipe_d[l][0] = push_i[l];
      for (int unsigned s = 1; s < RD_LAT; s++) begin
        pipe_d[l][s] = pipe_q[l][s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Exit is also gated by reset so a read in flight at reset is never returned.
  always_comb begin
    m0_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_rvalid_o = 1'b0;
    m1_rdata_o  = '0;
    lane_data   = '0;
    for (int unsigned l = 0; l < 2; l++) begin
      lane_data = (pipe_q[l][RD_LAT-1].port == PORT0) ? i_dout0 : i_dout1;
      if (pipe_q[l][RD_LAT-1].valid && !rst_i) begin
        if (pipe_q[l][RD_LAT-1].mid == 1'b0) begin
          m0_rvalid_o = 1'b1;
          m0_rdata_o  = lane_data;
        end else begin
          m1_rvalid_o = 1'b1;
          m1_rdata_o  = lane_data;
        end
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Steers two requesters onto a 1RW+1R SRAM macro with round-robin write arbitration.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wmask_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wmask_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                o_csb0,
  output logic                o_web0,
  output logic [DATA_W/8-1:0] o_wmask0,
  output logic [ADDR_W-1:0]   o_waddr0,
  output logic [DATA_W-1:0]   o_din0,
  input  logic [DATA_W-1:0]   i_dout0,
  output logic                o_csb1,
  output logic [ADDR_W-1:0]   o_addr1,
  input  logic [DATA_W-1:0]   i_dout1
);

  localparam int unsigned MW = DATA_W / 8;

  logic [1:0]             rd, wr, we;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata;
  logic [1:0][MW-1:0]     wmask;

  logic rr_ptr_q, rr_ptr_d;
  logic p0_use, p0_mid, p1_use, p1_mid, other;
  logic p0_wr;
  rd_entry_t [1:0] push;

  assign we    = {m1_we_i, m0_we_i};
  assign rd    = {m1_req_i & ~m1_we_i, m0_req_i & ~m0_we_i};
  assign wr    = {m1_req_i & m1_we_i, m0_req_i & m0_we_i};
  assign addr  = {m1_addr_i, m0_addr_i};
  assign wdata = {m1_wdata_i, m0_wdata_i};
  assign wmask = {m1_wmask_i, m0_wmask_i};

  always_comb begin
    p0_use   = 1'b0;
    p0_mid   = 1'b0;
    p1_use   = 1'b0;
    p1_mid   = 1'b0;
    other    = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (!rst_i) begin
      if (wr[0] && wr[1]) begin
        p0_use   = 1'b1;
        p0_mid   = rr_ptr_q;
        rr_ptr_d = ~rr_ptr_q;
      end else if (wr[0] || wr[1]) begin
        // Writer owns port0; the other side reads on port1 unless it hits the same word.
        p0_use = 1'b1;
        p0_mid = wr[1];
        other  = ~wr[1];
        if (rd[other] && (addr[other] != addr[p0_mid])) begin
          p1_use = 1'b1;
          p1_mid = other;
        end
      end else if (rd[0] && rd[1]) begin
        p0_use = 1'b1;
        p0_mid = 1'b1;
        p1_use = 1'b1;
        p1_mid = 1'b0;
      end else if (rd[0] || rd[1]) begin
        p1_use = 1'b1;
        p1_mid = rd[1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    p0_wr    = p0_use && we[p0_mid];
    o_csb0   = ~p0_use;
    o_web0   = ~p0_wr;
    o_waddr0 = p0_use ? addr[p0_mid] : '0;
    o_wmask0 = p0_wr ? wmask[p0_mid] : '0;
    o_din0   = p0_wr ? wdata[p0_mid] : '0;
    o_csb1   = ~p1_use;
    o_addr1  = p1_use ? addr[p1_mid] : '0;
    m0_gnt_o = (p0_use && !p0_mid) || (p1_use && !p1_mid);
    m1_gnt_o = (p0_use && p0_mid) || (p1_use && p1_mid);
    push[0].valid = p0_use && !p0_wr;
    push[0].mid   = p0_mid;
    push[0].port  = PORT0;
    push[1].valid = p1_use;
    push[1].mid   = p1_mid;
    push[1].port  = PORT1;
  end

  sram_rd_tracker #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_tracker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .i_dout0     (i_dout0),
    .i_dout1     (i_dout1),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_rdata_o  (m1_rdata_o)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1RW+1R macro (RD_LAT=1).
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [8:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [8:0]  waddr0, addr1;
  logic [31:0] din0, dout0, dout1;
  logic [31:0] mem [512];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W (9),
    .DATA_W (32),
    .RD_LAT (1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_wmask_i  (m0_wmask),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_wmask_i  (m1_wmask),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .o_csb0      (csb0),
    .o_web0      (web0),
    .o_wmask0    (wmask0),
    .o_waddr0    (waddr0),
    .o_din0      (din0),
    .i_dout0     (dout0),
    .o_csb1      (csb1),
    .o_addr1     (addr1),
    .i_dout1     (dout1)
  );

  always @(posedge clk) begin
    if (!csb0 && !web0) begin
      for (int b = 0; b < 4; b++)
        if (wmask0[b]) mem[waddr0][b*8 +: 8] <= din0[b*8 +: 8];
    end
    if (!csb0 && web0) dout0 <= mem[waddr0];
    if (!csb1) dout1 <= mem[addr1];
  end

  always @(negedge clk) begin
    #2;
    if (!rst && !csb0 && !csb1 && !web0 && (waddr0 == addr1)) begin
      errors++;
      $display("FAIL rw_same_addr: waddr0=%h addr1=%h both selected with web0=0", waddr0, addr1);
    end
    if (m0_gnt && m1_gnt && m0_req && m1_req && m0_we && m1_we) begin
      errors++;
      $display("FAIL port0_double_grant: m0_gnt=%b m1_gnt=%b required not both", m0_gnt, m1_gnt);
    end
  end

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 9'h005; m0_wmask = 4'hF;
    m1_req = 1; m1_addr = 9'h006;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, csb0, csb1, web0} !== 5'b00111) begin
      errors++;
      $display("FAIL reset_outputs: gnt/csb0/csb1/web0=%b required 00111", {m0_gnt, m1_gnt, csb0, csb1, web0});
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_rvalid: rvalid=%b%b rdata=%h/%h required all 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_dual_read();
    @(negedge clk);
    m0_req = 1; m0_addr = 9'h010;
    m1_req = 1; m1_addr = 9'h1FF;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, csb0, csb1, web0} !== 5'b11001 || addr1 !== 9'h010 || waddr0 !== 9'h1FF) begin
      errors++;
      $display("FAIL dual_read_grant: gnt/csb0/csb1/web0=%b addr0=%h addr1=%h required 11001 1ff 010",
               {m0_gnt, m1_gnt, csb0, csb1, web0}, waddr0, addr1);
    end
    @(negedge clk);
    idle();
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b11 || m0_rdata !== 32'hA5A5_0010 || m1_rdata !== 32'h1234_01FF) begin
      errors++;
      $display("FAIL dual_read_data: rvalid=%b%b rdata=%h/%h required 11 a5a50010/123401ff",
               m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
    @(negedge clk);
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00 || m0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rvalid_one_cycle: rvalid=%b%b rdata0=%h required 00 0", m0_rvalid, m1_rvalid, m0_rdata);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 9'h020; m0_wdata = 32'hDEAD_BEEF; m0_wmask = 4'hF;
    m1_req = 1; m1_addr = 9'h021;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, csb0, csb1, web0} !== 5'b11000 || waddr0 !== 9'h020 || addr1 !== 9'h021
        || din0 !== 32'hDEAD_BEEF || wmask0 !== 4'hF) begin
      errors++;
      $display("FAIL write_read_grant: gnt/csb/web=%b addr0=%h addr1=%h din0=%h mask=%h required 11000 020 021 deadbeef f",
               {m0_gnt, m1_gnt, csb0, csb1, web0}, waddr0, addr1, din0, wmask0);
    end
    @(negedge clk);
    idle();
    checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'hCAFE_0021) begin
      errors++;
      $display("FAIL write_read_data: rvalid=%b%b m1_rdata=%h required 01 cafe0021", m0_rvalid, m1_rvalid, m1_rdata);
    end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 9'h020; m0_wdata = 32'hDEAD_BEEF; m0_wmask = 4'hF;
    m1_req = 1; m1_addr = 9'h020;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, csb0, csb1, web0} !== 5'b10010) begin
      errors++;
      $display("FAIL hazard_block: gnt/csb0/csb1/web0=%b required 10010", {m0_gnt, m1_gnt, csb0, csb1, web0});
    end
    @(negedge clk);
    m0_req = 0; m0_we = 0;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, csb1} !== 3'b010 || addr1 !== 9'h020) begin
      errors++;
      $display("FAIL hazard_retry: gnt/csb1=%b addr1=%h required 010 020", {m0_gnt, m1_gnt, csb1}, addr1);
    end
    @(negedge clk);
    idle();
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL hazard_data: m1_rvalid=%b m1_rdata=%h required 1 deadbeef", m1_rvalid, m1_rdata);
    end
  endtask

  task automatic test_round_robin();
    int w0 = 0, w1 = 0, max_w = 0;
    logic exp0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m0_req = 1; m0_we = 1; m0_addr = 9'h040; m0_wdata = 32'h0000_0040; m0_wmask = 4'hF;
    m1_req = 1; m1_we = 1; m1_addr = 9'h041; m1_wdata = 32'h0000_0041; m1_wmask = 4'hF;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp0 = ((k % 2) == 0);
      checks++;
      if ({m0_gnt, m1_gnt} !== {exp0, ~exp0}) begin
        errors++;
        $display("FAIL rr_cycle%0d: gnt=%b%b required %b%b", k, m0_gnt, m1_gnt, exp0, ~exp0);
      end
      w0 = m0_gnt ? 0 : w0 + 1;
      w1 = m1_gnt ? 0 : w1 + 1;
      if (w0 > max_w) max_w = w0;
      if (w1 > max_w) max_w = w1;
    end
    checks++;
    if (max_w >= 2) begin
      errors++;
      $display("FAIL rr_starvation: longest wait %0d cycles required under 2", max_w);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_byte_mask();
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 9'h030; m0_wdata = 32'h1122_3344; m0_wmask = 4'b0101;
    #1;
    checks++;
    if (m0_gnt !== 1'b1 || wmask0 !== 4'b0101 || csb1 !== 1'b1 || web0 !== 1'b0) begin
      errors++;
      $display("FAIL mask_write: gnt=%b mask0=%b csb1=%b web0=%b required 1 0101 1 0", m0_gnt, wmask0, csb1, web0);
    end
    @(negedge clk);
    m0_we = 0; m0_wdata = '0; m0_wmask = '0;
    #1;
    checks++;
    if ({m0_gnt, csb0, csb1} !== 3'b110 || addr1 !== 9'h030) begin
      errors++;
      $display("FAIL mask_read_grant: gnt/csb0/csb1=%b addr1=%h required 110 030", {m0_gnt, csb0, csb1}, addr1);
    end
    @(negedge clk);
    idle();
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hFF22_FF44) begin
      errors++;
      $display("FAIL mask_data: m0_rvalid=%b m0_rdata=%h required 1 ff22ff44", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  addrs [3] = '{9'h010, 9'h1FF, 9'h021};
    logic [31:0] exps  [3] = '{32'hA5A5_0010, 32'h1234_01FF, 32'hCAFE_0021};
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i < 3) begin
        m0_req = 1; m0_addr = addrs[i];
      end else begin
        idle();
      end
      #1;
      if (i > 0) begin
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== exps[i-1]) begin
          errors++;
          $display("FAIL b2b_data%0d: m0_rvalid=%b m0_rdata=%h required 1 %h", i - 1, m0_rvalid, m0_rdata, exps[i-1]);
        end
      end
      if (i < 3) begin
        checks++;
        if (m0_gnt !== 1'b1) begin
          errors++;
          $display("FAIL b2b_grant%0d: m0_gnt=%b required 1", i, m0_gnt);
        end
      end
    end
  endtask

  task automatic test_reset_flush();
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 9'h050; m0_wdata = 32'h5; m0_wmask = 4'hF;
    m1_req = 1; m1_we = 1; m1_addr = 9'h051; m1_wdata = 32'h6; m1_wmask = 4'hF;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL flush_conflict: gnt=%b%b required 10", m0_gnt, m1_gnt);
    end
    @(negedge clk);
    idle();
    m1_req = 1; m1_addr = 9'h010;
    #1;
    checks++;
    if (m1_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_read_grant: m1_gnt=%b required 1", m1_gnt);
    end
    @(negedge clk);
    rst = 1'b1;
    idle();
    m0_req = 1; m0_we = 1; m0_addr = 9'h052; m0_wmask = 4'hF;
    #1;
    checks++;
    if ({m1_rvalid, m0_rvalid, m0_gnt, csb0, csb1, web0} !== 6'b000111 || m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL flush_in_reset: rvalid1/rvalid0/gnt0/csb0/csb1/web0=%b m1_rdata=%h required 000111 0",
               {m1_rvalid, m0_rvalid, m0_gnt, csb0, csb1, web0}, m1_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    m0_req = 1; m0_we = 1; m0_addr = 9'h050; m0_wdata = 32'h7; m0_wmask = 4'hF;
    m1_req = 1; m1_we = 1; m1_addr = 9'h051; m1_wdata = 32'h8; m1_wmask = 4'hF;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b1000) begin
      errors++;
      $display("FAIL flush_after_reset: gnt=%b%b rvalid=%b%b required 10 00", m0_gnt, m1_gnt, m0_rvalid, m1_rvalid);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[9'h010] = 32'hA5A5_0010;
    mem[9'h1FF] = 32'h1234_01FF;
    mem[9'h021] = 32'hCAFE_0021;
    mem[9'h030] = 32'hFFFF_FFFF;
    dout0 = '0;
    dout1 = '0;
    test_reset();
    test_dual_read();
    test_write_read();
    test_hazard();
    test_round_robin();
    test_byte_mask();
    test_back_to_back();
    test_reset_flush();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
